// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline execution controller and the debug unit:
// command encodings, controller state type and drain length.
package pipeline_pkg;

    localparam int unsigned DRAIN_CYCLES = 3;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_RUN   = 2'b01,
        CMD_STEP  = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_DUMP,
        ST_HALTED
    } exec_state_t;

endpackage

// File: rtl/pipeline_exec_controller_if.sv
// Debug-unit command handshake into the execution controller.
interface pipeline_exec_controller_if;
    import pipeline_pkg::*;

    logic cmd_valid;
    cmd_t cmd;
    logic cmd_ready;

    modport master (output cmd_valid, output cmd, input cmd_ready);
    modport slave  (input cmd_valid, input cmd, output cmd_ready);
endinterface

// File: rtl/pipeline_exec_controller.sv
// Run/step/halt sequencing for the 5-stage pipeline: stage enables, stall merge,
// HALT drain and dump handshake.
module pipeline_exec_controller
    import pipeline_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = pipeline_pkg::DRAIN_CYCLES,
    parameter int unsigned CNT_W        = 32
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    pipeline_exec_controller_if.slave    dbg,
    input  logic                         i_hdu_stall,
    input  logic                         i_halt_id,
    input  logic                         i_dump_done,
    output logic                         o_pipe_enable,
    output logic                         o_pc_write,
    output logic                         o_if_id_write,
    output logic                         o_ctrl_zero,
    output logic                         o_dump_start,
    output logic                         o_soft_reset,
    output logic                         o_halted,
    output logic [CNT_W-1:0]             o_cycle_count
);

    localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    exec_state_t   state, next_state;
    logic [DW-1:0] drain_cnt;
    logic          cmd_ready;
    logic          clear_hit;
    logic          draining;

    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        clear_hit  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (dbg.cmd_valid) begin
                    case (dbg.cmd)
                        CMD_RUN:   next_state = ST_RUN;
                        CMD_STEP:  next_state = ST_STEP;
                        CMD_CLEAR: clear_hit  = 1'b1;
                        default:   ;
                    endcase
                end
            end
            // HALT wins over a simultaneous load-use stall; the load retires in DRAIN.
            ST_RUN:   if (i_halt_id) next_state = ST_DRAIN;
            ST_STEP:  next_state = i_halt_id ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (drain_cnt == DRAIN_LAST) next_state = ST_DUMP;
            ST_DUMP:  if (i_dump_done) next_state = ST_HALTED;
            ST_HALTED: begin
                cmd_ready = 1'b1;
                if (dbg.cmd_valid && dbg.cmd == CMD_CLEAR) begin
                    clear_hit  = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign dbg.cmd_ready = cmd_ready;

    // Enables are combinational so the hazard stall takes effect in the same cycle.
    always_comb begin
        draining      = (state == ST_DRAIN);
        o_pipe_enable = (state == ST_RUN) || (state == ST_STEP) || draining;
        o_pc_write    = o_pipe_enable & ~i_hdu_stall & ~i_halt_id & ~draining;
        o_if_id_write = o_pc_write;
        o_ctrl_zero   = o_pipe_enable & (i_hdu_stall | draining);
        o_halted      = (state == ST_HALTED);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            o_dump_start  <= 1'b0;
            o_soft_reset  <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            state        <= next_state;
            drain_cnt    <= draining ? drain_cnt + DW'(1) : '0;
            o_dump_start <= (next_state == ST_DUMP) && (state != ST_DUMP);
            o_soft_reset <= clear_hit;
            if (clear_hit)
                o_cycle_count <= '0;
            else if (o_pipe_enable)
                o_cycle_count <= o_cycle_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench for pipeline_exec_controller with a cycle-level reference model.
module tb_pipeline_exec_controller;
    import pipeline_pkg::*;

    localparam int unsigned DRAIN = 3;
    localparam int unsigned CW    = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          hdu_stall, halt_id, dump_done;
    logic          pipe_enable, pc_write, if_id_write, ctrl_zero;
    logic          dump_start, soft_reset, halted;
    logic [CW-1:0] cycle_count;

    int checks = 0;
    int errors = 0;

    pipeline_exec_controller_if dbg ();

    pipeline_exec_controller #(.DRAIN_CYCLES(DRAIN), .CNT_W(CW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .dbg           (dbg),
        .i_hdu_stall   (hdu_stall),
        .i_halt_id     (halt_id),
        .i_dump_done   (dump_done),
        .o_pipe_enable (pipe_enable),
        .o_pc_write    (pc_write),
        .o_if_id_write (if_id_write),
        .o_ctrl_zero   (ctrl_zero),
        .o_dump_start  (dump_start),
        .o_soft_reset  (soft_reset),
        .o_halted      (halted),
        .o_cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks what the pipeline is doing as remaining work
    // (free running, one pending step, cycles of drain left, dump outstanding).
    bit          m_run, m_step, m_dump, m_pulse, m_soft, m_halted;
    int          m_drain_left;
    logic [CW-1:0] m_count;

    function automatic bit m_en();
        return m_run || m_step || (m_drain_left > 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0; m_step = 0; m_dump = 0; m_pulse = 0; m_soft = 0; m_halted = 0;
            m_drain_left = 0; m_count = '0;
        end else begin
            bit en, acc;
            int dl;
            en  = m_en();
            acc = dbg.cmd_valid && !(en || m_dump);
            dl  = m_drain_left;
            m_pulse = 0;
            m_soft  = 0;
            if (m_run) begin
                if (halt_id) begin m_run = 0; m_drain_left = DRAIN; end
            end else if (m_step) begin
                m_step = 0;
                if (halt_id) m_drain_left = DRAIN;
            end else if (dl > 0) begin
                m_drain_left = dl - 1;
                if (dl == 1) begin m_dump = 1; m_pulse = 1; end
            end else if (m_dump) begin
                if (dump_done) begin m_dump = 0; m_halted = 1; end
            end
            if (en) m_count = m_count + 1;
            if (acc) begin
                case (dbg.cmd)
                    CMD_CLEAR: begin m_count = '0; m_soft = 1; m_halted = 0; end
                    CMD_RUN:   if (!m_halted) m_run = 1;
                    CMD_STEP:  if (!m_halted) m_step = 1;
                    default:   ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        bit en;
        en = m_en();
        chk("pipe_enable", 32'(pipe_enable), 32'(en));
        chk("pc_write", 32'(pc_write), 32'(en && !hdu_stall && !halt_id && m_drain_left == 0));
        chk("if_id_write", 32'(if_id_write), 32'(en && !hdu_stall && !halt_id && m_drain_left == 0));
        chk("ctrl_zero", 32'(ctrl_zero), 32'(en && (hdu_stall || m_drain_left > 0)));
        chk("dump_start", 32'(dump_start), 32'(m_pulse));
        chk("soft_reset", 32'(soft_reset), 32'(m_soft));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("cmd_ready", 32'(dbg.cmd_ready), 32'(!(en || m_dump)));
        chk("cycle_count", cycle_count, m_count);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input cmd_t c);
        dbg.cmd_valid = 1'b1;
        dbg.cmd       = c;
        next_cycle();
        dbg.cmd_valid = 1'b0;
        dbg.cmd       = CMD_NOP;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_en"}, 32'(pipe_enable), 0);
        chk({tag, "_pc"}, 32'(pc_write), 0);
        chk({tag, "_ifid"}, 32'(if_id_write), 0);
        chk({tag, "_cz"}, 32'(ctrl_zero), 0);
        chk({tag, "_ds"}, 32'(dump_start), 0);
        chk({tag, "_sr"}, 32'(soft_reset), 0);
        chk({tag, "_hl"}, 32'(halted), 0);
        chk({tag, "_rdy"}, 32'(dbg.cmd_ready), 1);
        chk({tag, "_cnt"}, cycle_count, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        hdu_stall = 1'b0; halt_id = 1'b0; dump_done = 1'b0;
        dbg.cmd_valid = 1'b0; dbg.cmd = CMD_NOP;
        @(negedge clk);
        chk_reset_values("rst");
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        // RUN for 10 enabled cycles
        send(CMD_RUN);
        @(negedge clk); chk("run_en", 32'(pipe_enable), 1);
        repeat (10) next_cycle();
        @(negedge clk);
        chk("run_cnt10", cycle_count, 10);
        chk("run_rdy", 32'(dbg.cmd_ready), 0);

        // one-cycle load-use stall, plus a stray dump_done that must be ignored
        next_cycle();
        hdu_stall = 1'b1; dump_done = 1'b1;
        @(negedge clk);
        chk("stall_pc", 32'(pc_write), 0);
        chk("stall_ifid", 32'(if_id_write), 0);
        chk("stall_cz", 32'(ctrl_zero), 1);
        chk("stall_en", 32'(pipe_enable), 1);
        next_cycle();
        hdu_stall = 1'b0; dump_done = 1'b0;
        repeat (2) next_cycle();

        // HALT at cycle k
        halt_id = 1'b1;
        @(negedge clk); chk("halt_pc", 32'(pc_write), 0);
        next_cycle();
        halt_id = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            chk("drain_cz", 32'(ctrl_zero), 1);
            chk("drain_pc", 32'(pc_write), 0);
            chk("drain_ds", 32'(dump_start), 0);
            next_cycle();
        end
        @(negedge clk);
        chk("dump_start_k4", 32'(dump_start), 1);
        chk("dump_en", 32'(pipe_enable), 0);
        repeat (5) next_cycle();
        @(negedge clk); chk("dump_ds_once", 32'(dump_start), 0);
        dump_done = 1'b1;
        next_cycle();
        dump_done = 1'b0;
        @(negedge clk); chk("halted", 32'(halted), 1);

        // RUN and STEP while halted are accepted but ignored
        send(CMD_RUN);
        send(CMD_STEP);
        @(negedge clk);
        chk("halt_ignore_en", 32'(pipe_enable), 0);
        chk("halt_ignore_hl", 32'(halted), 1);

        // CLEAR from HALTED
        send(CMD_CLEAR);
        @(negedge clk);
        chk("clr_sr", 32'(soft_reset), 1);
        chk("clr_cnt", cycle_count, 0);
        chk("clr_hl", 32'(halted), 0);
        next_cycle();
        @(negedge clk); chk("clr_sr_once", 32'(soft_reset), 0);

        // STEP x3
        for (int i = 0; i < 3; i++) begin
            send(CMD_STEP);
            @(negedge clk); chk("step_en", 32'(pipe_enable), 1);
            next_cycle();
            @(negedge clk);
            chk("step_idle_en", 32'(pipe_enable), 0);
            chk("step_idle_rdy", 32'(dbg.cmd_ready), 1);
        end
        chk("step_cnt3", cycle_count, 3);

        // STEP with simultaneous stall and HALT drains, then reset mid-DUMP
        send(CMD_STEP);
        hdu_stall = 1'b1; halt_id = 1'b1;
        @(negedge clk);
        chk("sh_pc", 32'(pc_write), 0);
        chk("sh_cz", 32'(ctrl_zero), 1);
        next_cycle();
        hdu_stall = 1'b0; halt_id = 1'b0;
        repeat (3) next_cycle();
        @(negedge clk); chk("sh_dump_start", 32'(dump_start), 1);
        next_cycle();
        #2 rst_n = 1'b0;
        #1 chk_reset_values("arst");
        next_cycle();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk); chk("post_rst_ds", 32'(dump_start), 0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
